// File: rtl/station_sched.sv
// Issue scheduler for two reservation stations sharing one execution port:
// write-latency scoreboard, LSU/load-lock gating and oldest-first grant.
module station_sched #(
   parameter int unsigned WB_LAT = 2
) (
   input  logic       clk,
   input  logic       a_rst_n,
   input  logic [1:0] s_feed,
   input  logic [1:0] s_active,
   input  logic [1:0] s_ready,
   input  logic [2:0] s_a_adr0,
   input  logic [2:0] s_a_adr1,
   input  logic [2:0] s_b_adr0,
   input  logic [2:0] s_b_adr1,
   input  logic [1:0] s_bypass_b,
   input  logic [3:0] s_d_adr0,
   input  logic [3:0] s_d_adr1,
   input  logic [1:0] s_ld_mem,
   input  logic [1:0] s_st_mem,
   input  logic [1:0] s_lock_loads,
   input  logic       lsu_busy,
   input  logic       ex_stall,
   output logic [1:0] s_ack,
   output logic       ex_valid,
   output logic       ex_sel,
   output logic [7:0] busy_mask
);

   localparam logic [1:0] LAT = WB_LAT[1:0];

   logic [1:0] cnt [8];
   logic [7:0] busy;
   logic       age;
   logic       sel_q;
   logic [1:0] elig;
   logic       win;
   logic       grant;

   logic [2:0] a_adr [2];
   logic [2:0] b_adr [2];
   logic [3:0] d_adr [2];

   assign a_adr[0] = s_a_adr0;
   assign a_adr[1] = s_a_adr1;
   assign b_adr[0] = s_b_adr0;
   assign b_adr[1] = s_b_adr1;
   assign d_adr[0] = s_d_adr0;
   assign d_adr[1] = s_d_adr1;

   always_comb begin
      for (int r = 0; r < 8; r++) busy[r] = (cnt[r] != 2'd0);
   end

   assign busy_mask = busy;

   always_comb begin
      // NOTE: every output of this block gets a default before any branch, so no latches are inferred.
      elig = '0;
      for (int i = 0; i < 2; i++) begin
         logic me;
         logic other;
         logic other_locks;
         me          = 1'(i);
         other       = ~me;
         other_locks = (age == other) && s_active[other] && s_lock_loads[other];
         elig[me] = s_ready[me]
                  && !busy[a_adr[me]]
                  && !(busy[b_adr[me]] && !s_bypass_b[me])
                  && !(d_adr[me][3] && busy[d_adr[me][2:0]])
                  && !((s_ld_mem[me] || s_st_mem[me]) && lsu_busy)
                  && !(s_ld_mem[me] && other_locks);
      end
   end

   // Reset gates the grant combinationally so acks drop the instant a_rst_n falls.
   always_comb begin
      grant = 1'b0;
      win   = age;
      if (a_rst_n && !ex_stall) begin
         if (elig[age]) begin
            grant = 1'b1;
            win   = age;
         end else if (elig[~age]) begin
            grant = 1'b1;
            win   = ~age;
         end
      end
   end

   assign s_ack    = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign ex_valid = grant;
   assign ex_sel   = grant ? win : sel_q;

   // NOTE: the counter array is architectural state, not RAM, so it is cleared by reset like any flop.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         for (int r = 0; r < 8; r++) cnt[r] <= 2'd0;
      end else begin
         for (int r = 0; r < 8; r++) begin
            if (grant && d_adr[win][3] && d_adr[win][2:0] == 3'(r)) cnt[r] <= LAT;
            else if (cnt[r] != 2'd0)                                 cnt[r] <= cnt[r] - 2'd1;
         end
      end
   end

   // A simultaneous feed on both stations treats S0 as the older one.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         age   <= 1'b0;
         sel_q <= 1'b0;
      end else begin
         case (s_feed)
            2'b01:   age <= 1'b1;
            2'b10,
            2'b11:   age <= 1'b0;
            default: age <= age;
         endcase
         if (grant) sel_q <= win;
      end
   end

endmodule

// File: tb/tb_station_sched.sv
// Self-checking bench for station_sched: directed scenarios then random traffic,
// compared against a timestamp-based scoreboard model.
module tb_station_sched;

   localparam int WB_LAT = 2;

   logic       clk = 1'b0;
   logic       a_rst_n = 1'b0;
   logic [1:0] feed, active, ready, byp, ld, st, lock;
   logic [2:0] a_adr [2];
   logic [2:0] b_adr [2];
   logic [3:0] d_adr [2];
   logic       lsu_busy, ex_stall;
   logic [1:0] s_ack;
   logic       ex_valid, ex_sel;
   logic [7:0] busy_mask;

   int total = 0;
   int bad   = 0;

   // Model state: register r is readable from cycle free_at[r] onward.
   int   free_at [8];
   int   cyc;
   logic older;
   logic last_sel;

   always #5 clk = ~clk;

   station_sched #(.WB_LAT(WB_LAT)) dut (
      .clk(clk), .a_rst_n(a_rst_n),
      .s_feed(feed), .s_active(active), .s_ready(ready),
      .s_a_adr0(a_adr[0]), .s_a_adr1(a_adr[1]),
      .s_b_adr0(b_adr[0]), .s_b_adr1(b_adr[1]),
      .s_bypass_b(byp),
      .s_d_adr0(d_adr[0]), .s_d_adr1(d_adr[1]),
      .s_ld_mem(ld), .s_st_mem(st), .s_lock_loads(lock),
      .lsu_busy(lsu_busy), .ex_stall(ex_stall),
      .s_ack(s_ack), .ex_valid(ex_valid), .ex_sel(ex_sel), .busy_mask(busy_mask)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic m_busy(input logic [2:0] r);
      return free_at[r] > cyc;
   endfunction

   function automatic logic [7:0] m_mask();
      logic [7:0] m;
      for (int r = 0; r < 8; r++) m[r] = m_busy(3'(r));
      return m;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 8; r++) free_at[r] = 0;
      cyc      = 0;
      older    = 1'b0;
      last_sel = 1'b0;
   endtask

   task automatic model_eval(output logic gv, output logic gi);
      logic ok [2];
      for (int i = 0; i < 2; i++) begin
         int o;
         o = 1 - i;
         ok[i] = ready[i] && !m_busy(a_adr[i]) && !(m_busy(b_adr[i]) && !byp[i])
              && !(d_adr[i][3] && m_busy(d_adr[i][2:0]))
              && !((ld[i] || st[i]) && lsu_busy)
              && !(ld[i] && int'(older) == o && active[o] && lock[o]);
      end
      gv = 1'b0;
      gi = last_sel;
      if (!ex_stall) begin
         if (ok[older])       begin gv = 1'b1; gi = older;  end
         else if (ok[!older]) begin gv = 1'b1; gi = !older; end
      end
   endtask

   // Check all outputs against the model, then clock one cycle and update the model.
   task automatic step(input string tag);
      logic gv, gi;
      logic [1:0] exp_ack;
      #1;
      model_eval(gv, gi);
      exp_ack = gv ? (gi ? 2'b10 : 2'b01) : 2'b00;
      chk({tag, "/ack"},   8'(s_ack),    8'(exp_ack));
      chk({tag, "/valid"}, 8'(ex_valid), 8'(gv));
      chk({tag, "/sel"},   8'(ex_sel),   8'(gi));
      chk({tag, "/busy"},  busy_mask,    m_mask());
      @(posedge clk);
      if (gv && d_adr[gi][3]) free_at[d_adr[gi][2:0]] = cyc + 1 + WB_LAT;
      if (gv) last_sel = gi;
      case (feed)
         2'b01:        older = 1'b1;
         2'b10, 2'b11: older = 1'b0;
         default:      ;
      endcase
      cyc++;
      #1;
   endtask

   task automatic quiet();
      feed = 2'b00; active = 2'b11; ready = 2'b00; byp = 2'b00;
      ld = 2'b00; st = 2'b00; lock = 2'b00; lsu_busy = 1'b0; ex_stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
         a_adr[i] = 3'd0; b_adr[i] = 3'd0; d_adr[i] = 4'd0;
      end
   endtask

   task automatic reset_mid(input string tag);
      #2;
      a_rst_n = 1'b0;
      #1;
      chk({tag, "/ack"},   8'(s_ack),    8'h00);
      chk({tag, "/valid"}, 8'(ex_valid), 8'h00);
      chk({tag, "/sel"},   8'(ex_sel),   8'h00);
      chk({tag, "/busy"},  busy_mask,    8'h00);
      @(posedge clk);
      #1;
      a_rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      model_reset();
      quiet();
      ready = 2'b11;

      // Reset holds acks low even with both stations ready.
      #3;
      chk("rst/ack",   8'(s_ack),    8'h00);
      chk("rst/valid", 8'(ex_valid), 8'h00);
      chk("rst/busy",  busy_mask,    8'h00);
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      a_rst_n = 1'b1;
      #1;
      chk("rel/ack", 8'(s_ack),  8'h01);
      chk("rel/sel", 8'(ex_sel), 8'h00);
      step("rel");

      // RAW on r3: S1 waits WB_LAT cycles behind S0.
      quiet();
      ready = 2'b11; d_adr[0] = 4'b1011; a_adr[1] = 3'd3;
      #1 chk("raw/first", 8'(s_ack), 8'h01);
      step("raw0");
      ready = 2'b10; d_adr[0] = 4'd0;
      #1 chk("raw/busy1", busy_mask, 8'h08);
      chk("raw/stall1", 8'(s_ack), 8'h00);
      step("raw1");
      #1 chk("raw/busy2", busy_mask, 8'h08);
      chk("raw/stall2", 8'(s_ack), 8'h00);
      step("raw2");
      #1 chk("raw/go", 8'(s_ack), 8'h02);
      chk("raw/free", busy_mask, 8'h00);
      step("raw3");

      // Feed on S0 makes S1 older.
      quiet();
      feed = 2'b01;
      step("age_feed");
      feed = 2'b00; ready = 2'b11;
      #1 chk("age/s1", 8'(s_ack), 8'h02);
      step("age0");
      ready = 2'b01;
      #1 chk("age/s0", 8'(s_ack), 8'h01);
      step("age1");

      // Load on S1 blocked by LSU busy; ALU on S0 goes.
      quiet();
      ready = 2'b11; ld = 2'b10; lsu_busy = 1'b1;
      #1 chk("lsu/alu", 8'(s_ack), 8'h01);
      step("lsu0");
      ready = 2'b10;
      #1 chk("lsu/wait", 8'(s_ack), 8'h00);
      step("lsu1");
      lsu_busy = 1'b0;
      #1 chk("lsu/go", 8'(s_ack), 8'h02);
      step("lsu2");

      // Load lock held by older S0.
      quiet();
      feed = 2'b10;
      step("lock_feed");
      feed = 2'b00; lock = 2'b01; ready = 2'b10; ld = 2'b10;
      #1 chk("lock/blk0", 8'(s_ack), 8'h00);
      step("lock0");
      step("lock1");
      active = 2'b10;
      #1 chk("lock/rel", 8'(s_ack), 8'h02);
      step("lock2");
      active = 2'b11; ld = 2'b00;
      #1 chk("lock/alu", 8'(s_ack), 8'h02);
      step("lock3");

      // ex_stall with a live scoreboard entry on r5.
      quiet();
      ready = 2'b01; d_adr[0] = 4'b1101;
      step("stall_set");
      ready = 2'b11; d_adr[0] = 4'd0; ex_stall = 1'b1;
      #1 chk("stall/ack1", 8'(s_ack), 8'h00);
      chk("stall/busy1", busy_mask, 8'h20);
      step("stall1");
      #1 chk("stall/ack2", 8'(s_ack), 8'h00);
      chk("stall/busy2", busy_mask, 8'h20);
      step("stall2");
      chk("stall/busy3", busy_mask, 8'h00);
      step("stall3");
      ex_stall = 1'b0;
      #1 chk("stall/rel", 8'(s_ack), 8'h01);
      step("stall4");

      // Same destination on both: loser sees WAW for WB_LAT cycles.
      quiet();
      ready = 2'b11; d_adr[0] = 4'b1010; d_adr[1] = 4'b1010;
      step("waw0");
      ready = 2'b10;
      for (int k = 0; k < 3; k++) step("waw");

      // Reset mid-operation clears the scoreboard immediately.
      quiet();
      ready = 2'b01; d_adr[0] = 4'b1111;
      step("mid_set");
      ready = 2'b11; d_adr[0] = 4'd0;
      reset_mid("mid");
      #1 chk("mid/after", 8'(s_ack), 8'h01);
      step("mid_after");

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         feed     = 2'($urandom_range(0, 3));
         active   = 2'($urandom_range(0, 3));
         ready    = 2'($urandom_range(0, 3)) | 2'($urandom_range(0, 3));
         byp      = 2'($urandom_range(0, 3));
         ld       = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
         st       = 2'($urandom_range(0, 3)) & ~ld;
         lock     = 2'($urandom_range(0, 3));
         lsu_busy = ($urandom_range(0, 3) == 0);
         ex_stall = ($urandom_range(0, 7) == 0);
         for (int i = 0; i < 2; i++) begin
            a_adr[i] = 3'($urandom_range(0, 7));
            b_adr[i] = 3'($urandom_range(0, 7));
            d_adr[i] = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 149) == 0) reset_mid("rnd_rst");
         else                             step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/station_sched.md
Name: station_sched

Overview:
- Issue scheduler shared by two reservation stations (S0, S1) in front of one ALU/AGU/LSU execution port.
- Each cycle it picks at most one ready station and returns its sched_ack. A station is eligible only when:
  - it has no register hazard, checked against a write-latency scoreboard;
  - the LSU is free for its memory ops;
  - no load-ordering lock is held by an older station.
- Oldest-first priority. The datapath muxes the winning station's operand and control bus using ex_sel.

Parameters:
- WB_LAT, 2, cycles from issue until the destination register is readable; legal range 1..3 (2-bit counters).

Ports:
- clk  in  1  clock, rising edge
- a_rst_n  in  1  asynchronous reset, active low
- s_feed  in  2  per station: new iop latched this cycle (id_feed & id_ack)
- s_active  in  2  per station: status != COMPLETE
- s_ready  in  2  per station: uop ready to issue
- s_a_adr0 / s_a_adr1  in  3  A operand register
- s_b_adr0 / s_b_adr1  in  3  B operand register
- s_bypass_b  in  2  B comes from k16; B operand not hazard-checked
- s_d_adr0 / s_d_adr1  in  4  bit3 = write enable, [2:0] = destination
- s_ld_mem  in  2  uop is a load
- s_st_mem  in  2  uop is a store
- s_lock_loads  in  2  station holds the load-ordering lock
- lsu_busy  in  1  LSU cannot accept a memory uop this cycle
- ex_stall  in  1  execution port back-pressure; suppresses all issue
- s_ack  out  2  sched_ack per station, one-hot or zero
- ex_valid  out  1  a uop issues this cycle (= |s_ack)
- ex_sel  out  1  winning station index; holds last value when ex_valid = 0
- busy_mask  out  8  per-register scoreboard busy bits

Behaviour:

Reset (a_rst_n low, asynchronous):
- All scoreboard counters = 0; busy_mask = 0.
- age = 0 (S0 is older); ex_sel = 0.
- s_ack = 0 and ex_valid = 0, forced regardless of other inputs.

Issue path:
- s_ack, ex_valid and ex_sel are combinational from current state and inputs. Same-cycle response is required because a station advances on sched_ack in the same cycle.
- Scoreboard and age update on the rising clk edge.

Age tracking (1 flop; age = index of the older station):
- s_feed = 01 → age <= 1 (S0 becomes youngest).
- s_feed = 10 → age <= 0.
- s_feed = 11 → age <= 0 (S0 treated as older).
- s_feed = 00 → age holds.

Scoreboard (cnt[r], 2 bits each, r = 0..7):
- busy[r] = (cnt[r] != 0); busy_mask = busy.
- Every edge: cnt[r] decrements if nonzero.
- On issue with d_adr[3] = 1: cnt[d_adr[2:0]] <= WB_LAT. Set wins over decrement on the same register.
- No forwarding: a register with cnt = 1 is still busy that cycle.

Eligibility, elig[i] = s_ready[i] AND all of:
- NOT busy[a_adr]
- NOT (busy[b_adr] AND NOT bypass_b)
- NOT (d_adr[3] AND busy[d_adr[2:0]]) (WAW)
- NOT ((ld | st) AND lsu_busy)
- NOT (ld AND other station is older AND s_active[other] AND s_lock_loads[other])

Grant:
- ex_stall = 1 → no grant.
- Otherwise the older station wins if eligible, else the younger one if eligible.
- s_ack[i] = grant to i; ex_sel = i.

Boundaries:
- Only one station ready → it issues if eligible, independent of age.
- Both stations target the same destination register → the loser issues next cycle and sees WAW busy; it waits WB_LAT cycles.
- Reset asserted mid-operation clears the scoreboard immediately; acks drop in the same cycle.

Test Plan:
- Reset with both s_ready = 1 and no hazards → s_ack = 00 during reset. After release: s_ack = 01, ex_sel = 0.
- S0 issues d = 1011 (write r3) with WB_LAT = 2; S1 ready with a_adr = 3 → S1 stalls 2 cycles. busy_mask = 0x08 for 2 cycles, then S1 acked on the 3rd cycle.
- s_feed = 01, then both stations ready and hazard-free → S1 (older) acked first, S0 the next cycle.
- S1 is a load, lsu_busy = 1, S0 is an ALU uop → S0 acked; S1 acked the first cycle lsu_busy = 0.
- Older S0 active with s_lock_loads = 1; younger S1 load is ready → S1 blocked until s_active[0] = 0. A younger S1 ALU uop in the same situation is not blocked.
- ex_stall = 1 with both stations eligible → s_ack = 00 and the scoreboard only decrements. Releasing ex_stall → the older station is acked.
